smg_disp_ctrl: RTL and testbench
================================

# smg_disp_ctrl

Six-digit seven-segment display controller. It sits between the SPI receive path and the board's digit/segment pins. It accepts a 24-bit hex value plus decimal points through a valid/ready handshake, double-buffers it, and applies it only at frame boundaries so no frame ever mixes two values. It time-multiplexes the six digits, with an anti-ghosting blank window at the start of every digit slot.

## Interface
Parameters:
- T1MS, 49999: digit slot length minus one, in CLK cycles (1 ms at 50 MHz). 16-bit.
- BLANK, 16: cycles at the start of each slot with all digits and segments off. Legal range 0 ≤ BLANK < T1MS.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  asynchronous, active-low reset.
- Data_In  in  24  six hex nibbles; bits 23:20 are digit 1 (leftmost), bits 3:0 are digit 6.
- Dp_In  in  6  decimal point per digit, active-high; bit 5 is digit 1.
- Load_Valid  in  1  producer presents Data_In/Dp_In.
- Load_Ready  out  1  controller can accept a load.
- Scan_Sig  out  6  digit select, active-low; bit 5 is digit 1.
- Seg_Sig  out  8  segments, active-low common-anode, {dp,g,f,e,d,c,b,a}.
- Frame_Done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Slot counter C counts 0..T1MS, then wraps to 0. Digit index D runs 0..5 and advances when C==T1MS. D wraps 5→0.
- The cycle where C==T1MS and D==5 is the frame boundary. Frame_Done pulses in the following cycle.
- Buffers:
  - Pending buffer: 24 data + 6 dp bits plus a pending flag.
  - Display buffer: 24 data + 6 dp bits.
- Handshake:
  - Load_Ready = !pending.
  - A transfer happens when Load_Valid && Load_Ready on a rising edge. It captures the inputs into the pending buffer and sets pending.
  - The producer may hold Load_Valid indefinitely. Data is sampled only on a transfer.
- At the frame boundary, if pending==1: the pending buffer copies into the display buffer and pending clears.
- Simultaneous transfer and boundary: a transfer can only occur when pending==0, so the display is unchanged. The new data becomes pending and is applied at the next boundary.
- Slot output:
  - While C < BLANK: Scan_Sig=6'b111111 and Seg_Sig=8'hFF.
  - Otherwise: Scan_Sig drives a single 0 at bit (5-D).
  - Seg_Sig is the code for nibble D of the display buffer, with bit 7 cleared when that digit's dp is set.
- Hex codes: 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E.
- Reset mid-operation: everything returns to reset state immediately and any pending load is lost.

## Timing
- Reset values:
  - Scan_Sig=6'b111111, Seg_Sig=8'hFF, Load_Ready=1, Frame_Done=0.
  - C=0, D=0, pending=0, both buffers all zero.
- Scan_Sig and Seg_Sig are registered. They reflect the (C,D) value of the previous cycle.
- Slot length is T1MS+1 cycles. Frame length is 6·(T1MS+1) cycles.
- Load_Ready falls in the cycle after a transfer. It rises in the cycle after the boundary that consumes the pending data.
- Worst-case load-to-display latency is 2 frames plus 1 cycle.

## Configuration
- SMG_LZB_EN defined: leading-zero blanking.
  - Digits 1..5 are blanked when their nibble and every more-significant nibble are 0. Blanked means segments a–g off.
  - A blanked digit's dp is still honoured.
  - Digit 6 is never blanked.
- SMG_LZB_EN undefined: every digit shows its hex code.

## Structure
- Package smg_pkg holds:
  - the 16-entry hex→segment constant table;
  - digit count (6);
  - SEG_OFF=8'hFF and SCAN_OFF=6'b111111.
- Sub-module smg_encode is combinational: 4-bit nibble + dp + blank → 8-bit Seg code. It is instantiated once, on the selected digit.

## Test plan
Run with T1MS=9 and BLANK=2.
- Reset: assert RSTn=0 mid-slot → all outputs take reset values within the same cycle. After release, digit 1 selects (Scan_Sig=011111) from output cycle 3.
- Scan: no loads for 120 cycles → Scan_Sig cycles 011111, 101111, 110111, 111011, 111101, 111110, 10 cycles each, with 2 all-ones cycles at each slot start. Frame_Done pulses every 60 cycles.
- Load: Data_In=24'h123456, Dp_In=6'b000100 mid-frame → Load_Ready=0 next cycle and the display is unchanged until the boundary. The next frame shows F9, A4, B0, 99&7F(=19), 92, 82. Load_Ready returns to 1.
- Back-pressure: second load 24'hABCDEF held valid while pending → not accepted until one cycle after the boundary. It is displayed one frame later as 88, 83, C6, A1, 86, 8E.
- Boundary collision: Load_Valid asserted exactly on the boundary cycle with pending=0 → the current frame keeps its old value, and the new value appears from the following boundary.
- Leading-zero blanking: load 24'h000305 → with SMG_LZB_EN the digits show FF, FF, FF, B0, C0, 92. Without it they show C0, C0, C0, B0, C0, 92.

Source files
------------

// File: rtl/smg_pkg.sv
// Shared constants for the six-digit seven-segment display controller:
// digit count, idle pin levels and the hex-to-segment table.
package smg_pkg;

    localparam int          DIGITS     = 6;
    localparam logic [2:0]  LAST_DIGIT = 3'(DIGITS - 1);
    localparam logic [7:0]  SEG_OFF    = 8'hFF;
    localparam logic [5:0]  SCAN_OFF   = 6'b111111;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is off in every entry.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // True when the nibble of `digit` and every more-significant nibble are zero.
    function automatic logic lead_zero(input logic [23:0] data, input logic [2:0] digit);
        logic z;
        z = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i <= int'(digit)) z &= (data[23-4*i -: 4] == 4'h0);
        end
        return z;
    endfunction

endpackage

// File: rtl/smg_encode.sv
// Combinational segment encoder for one digit: hex code, optional blanking
// of segments a-g, and the decimal point (dp survives blanking).
module smg_encode
    import smg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    logic [7:0] w_code;

    assign w_code = i_blank ? SEG_OFF : HEX_SEG[i_nibble];
    assign o_seg  = {w_code[7] & ~i_dp, w_code[6:0]};

endmodule

// File: rtl/smg_disp_ctrl.sv
// Six-digit multiplexed display with double-buffered frame-aligned updates.
// Define SMG_LZB_EN to blank leading zero digits (digit 6 always shown).
module smg_disp_ctrl
    import smg_pkg::*;
#(
    parameter logic [15:0] T1MS  = 16'd49999,
    parameter logic [15:0] BLANK = 16'd16
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [23:0] Data_In,
    input  logic [5:0]  Dp_In,
    input  logic        Load_Valid,
    output logic        Load_Ready,
    output logic [5:0]  Scan_Sig,
    output logic [7:0]  Seg_Sig,
    output logic        Frame_Done
);

    logic [15:0] r_cnt;
    logic [2:0]  r_digit;
    logic        r_pending;
    logic [23:0] r_pend_data, r_disp_data;
    logic [5:0]  r_pend_dp,   r_disp_dp;
    logic [5:0]  r_scan;
    logic [7:0]  r_seg;
    logic        r_frame_done;

    logic        w_slot_end, w_boundary, w_transfer, w_blank_win, w_lz_blank, w_dp;
    logic [3:0]  w_nibble;
    logic [7:0]  w_seg_code;
    logic [5:0]  w_scan;

    assign w_slot_end  = (r_cnt == T1MS);
    assign w_boundary  = w_slot_end && (r_digit == LAST_DIGIT);
    assign w_transfer  = Load_Valid && !r_pending;
    assign w_blank_win = (r_cnt < BLANK);
    assign Load_Ready  = !r_pending;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt   <= '0;
            r_digit <= '0;
        end else if (w_slot_end) begin
            r_cnt   <= '0;
            r_digit <= (r_digit == LAST_DIGIT) ? 3'd0 : r_digit + 3'd1;
        end else begin
            r_cnt   <= r_cnt + 16'd1;
        end
    end

    // NOTE: the buffers are plain flops, not RAM, so they take the all-zero
    // reset value; a reset drops any pending load.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pending   <= 1'b0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_disp_data <= '0;
            r_disp_dp   <= '0;
        end else if (w_transfer) begin
            r_pending   <= 1'b1;
            r_pend_data <= Data_In;
            r_pend_dp   <= Dp_In;
        end else if (w_boundary && r_pending) begin
            r_pending   <= 1'b0;
            r_disp_data <= r_pend_data;
            r_disp_dp   <= r_pend_dp;
        end
    end

    // NOTE: defaults ahead of the case keep this purely combinational (no latch).
    always_comb begin
        w_nibble = 4'h0;
        w_dp     = 1'b0;
        case (r_digit)
            3'd0:    begin w_nibble = r_disp_data[23:20]; w_dp = r_disp_dp[5]; end
            3'd1:    begin w_nibble = r_disp_data[19:16]; w_dp = r_disp_dp[4]; end
            3'd2:    begin w_nibble = r_disp_data[15:12]; w_dp = r_disp_dp[3]; end
            3'd3:    begin w_nibble = r_disp_data[11:8];  w_dp = r_disp_dp[2]; end
            3'd4:    begin w_nibble = r_disp_data[7:4];   w_dp = r_disp_dp[1]; end
            3'd5:    begin w_nibble = r_disp_data[3:0];   w_dp = r_disp_dp[0]; end
            default: ;
        endcase
    end

`ifdef SMG_LZB_EN
    assign w_lz_blank = (r_digit != LAST_DIGIT) && lead_zero(r_disp_data, r_digit);
`else
    assign w_lz_blank = 1'b0;
`endif

    smg_encode u_encode (
        .i_nibble (w_nibble),
        .i_dp     (w_dp),
        .i_blank  (w_lz_blank),
        .o_seg    (w_seg_code)
    );

    assign w_scan = SCAN_OFF ^ (6'b100000 >> r_digit);

    // Pins are registered, so they lag the slot counter by one cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_scan       <= SCAN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_scan       <= w_blank_win ? SCAN_OFF : w_scan;
            r_seg        <= w_blank_win ? SEG_OFF  : w_seg_code;
            r_frame_done <= w_boundary;
        end
    end

    assign Scan_Sig   = r_scan;
    assign Seg_Sig    = r_seg;
    assign Frame_Done = r_frame_done;

endmodule

// File: tb/tb_smg_disp_ctrl.sv
// Self-checking bench for smg_disp_ctrl (T1MS=9, BLANK=2) against a
// cycle-count based reference model; honours SMG_LZB_EN like the RTL.
module tb_smg_disp_ctrl;

    localparam logic [15:0] T1MS  = 16'd9;
    localparam logic [15:0] BLANK = 16'd2;
    localparam int SLOT  = 10;
    localparam int FRAME = 60;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [23:0] Data_In;
    logic [5:0]  Dp_In;
    logic        Load_Valid;
    logic        Load_Ready;
    logic [5:0]  Scan_Sig;
    logic [7:0]  Seg_Sig;
    logic        Frame_Done;

    int total = 0;
    int bad   = 0;

    // Reference model: time since reset release plus the two buffers.
    int          t;
    bit          m_pend;
    logic [23:0] m_pdata, m_ddata;
    logic [5:0]  m_pdp,   m_ddp;

    logic [7:0] hex_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    smg_disp_ctrl #(.T1MS(T1MS), .BLANK(BLANK)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Data_In    (Data_In),
        .Dp_In      (Dp_In),
        .Load_Valid (Load_Valid),
        .Load_Ready (Load_Ready),
        .Scan_Sig   (Scan_Sig),
        .Seg_Sig    (Seg_Sig),
        .Frame_Done (Frame_Done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int d, input logic [23:0] data, input logic [5:0] dp);
        logic [23:0] upper;
        logic [7:0]  code;
        upper = data >> (4 * (5 - d));
        code  = hex_tab[upper[3:0]];
`ifdef SMG_LZB_EN
        if (d < 5 && upper == 24'h0) code = 8'hFF;
`endif
        if (dp[5-d]) code[7] = 1'b0;
        return code;
    endfunction

    task automatic model_reset();
        t = 0; m_pend = 0;
        m_pdata = '0; m_ddata = '0; m_pdp = '0; m_ddp = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_scan"},  {18'h0, Scan_Sig},   24'h3F);
        check({tag, "_seg"},   {16'h0, Seg_Sig},    24'hFF);
        check({tag, "_ready"}, {23'h0, Load_Ready}, 24'h1);
        check({tag, "_fdone"}, {23'h0, Frame_Done}, 24'h0);
    endtask

    // One clock: drive inputs, predict from the slot position, compare at negedge.
    task automatic step(input logic v, input logic [23:0] d, input logic [5:0] p);
        int c, dg;
        bit bnd;
        logic [5:0] e_scan;
        logic [7:0] e_seg;
        Load_Valid = v; Data_In = d; Dp_In = p;
        @(posedge CLK);
        c   = t % SLOT;
        dg  = (t / SLOT) % 6;
        bnd = (t % FRAME) == FRAME - 1;
        if (c < int'(BLANK)) begin
            e_scan = 6'b111111;
            e_seg  = 8'hFF;
        end else begin
            e_scan = ~(6'b000001 << (5 - dg));
            e_seg  = exp_seg(dg, m_ddata, m_ddp);
        end
        if (v && !m_pend) begin
            m_pend = 1; m_pdata = d; m_pdp = p;
        end else if (bnd && m_pend) begin
            m_pend = 0; m_ddata = m_pdata; m_ddp = m_pdp;
        end
        t++;
        @(negedge CLK);
        check("scan",  {18'h0, Scan_Sig},   {18'h0, e_scan});
        check("seg",   {16'h0, Seg_Sig},    {16'h0, e_seg});
        check("fdone", {23'h0, Frame_Done}, {23'h0, bnd});
        check("ready", {23'h0, Load_Ready}, {23'h0, !m_pend});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'(($urandom)), 6'($urandom));
    endtask

    task automatic async_reset(input string tag);
        #2 RSTn = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [23:0] rd;
        logic [5:0]  rp;
        int hold;

        RSTn = 1'b0; Load_Valid = 1'b0; Data_In = '0; Dp_In = '0;
        model_reset();
        #12 check_reset_outputs("por");
        @(negedge CLK);
        RSTn = 1'b1;

        // Free-running scan with reset-time (all zero) display buffer.
        idle(125);

        // Directed load mid-frame, then a full following frame.
        step(1'b1, 24'h123456, 6'b000100);
        idle(100);

        // Back-pressure: a load is pending while a second one is held valid.
        idle(25 - (t % FRAME) + FRAME);
        step(1'b1, 24'($urandom), 6'($urandom));
        for (int i = 0; i < 70; i++) step(1'b1, 24'hABCDEF, 6'b000000);
        idle(130);

        // Boundary collision: valid only on the boundary cycle itself.
        while ((t % FRAME) != FRAME - 1) step(1'b0, 24'h0, 6'h0);
        step(1'b1, 24'h9876A5, 6'b100001);
        idle(130);

        // Leading zeros.
        step(1'b1, 24'h000305, 6'b000000);
        idle(130);
        step(1'b1, 24'h000000, 6'b010000);
        idle(130);

        // Randomized loads with random hold times and leading-zero counts.
        for (int k = 0; k < 10; k++) begin
            idle($urandom_range(0, 90));
            rd   = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 5)));
            rp   = 6'($urandom);
            hold = $urandom_range(1, 80);
            for (int i = 0; i < hold; i++) step(1'b1, rd, rp);
        end
        idle(130);

        // Reset mid-slot with a load pending: it must be lost.
        idle(3);
        step(1'b1, 24'hFEDCBA, 6'b111111);
        idle(4);
        async_reset("midrst");
        idle(130);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
